// File: rtl/rip_mem_arbiter.sv
// rip_mem_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch (IF)
// and memory-access (MA) ports. At most one grant per cycle, MA has priority,
// and the 1-cycle-latency read data is routed back to whichever port owned the
// access issued in the previous cycle. IF responses can be killed in flight.
//
// Optional feature: define RIP_ARB_STARVE_GUARD_EN to enable the IF
// starvation guard (IF wins after STREAK_MAX consecutive MA grants while IF
// was waiting). Without it, MA priority is strict and STREAK_MAX is unused.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no access was issued last cycle, no response due
// ST_IF_RD | IF read issued last cycle, IF response due now
// ST_MA_RD | MA read issued last cycle, MA read data due now
// ST_MA_WR | MA write issued last cycle, MA write ack due now

module rip_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,

  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [3:0]        ma_be,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [31:0]       ma_wdata,
  output logic              ma_gnt,
  output logic              ma_rvalid,
  output logic [31:0]       ma_rdata,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_MA_RD = 2'd2,
    ST_MA_WR = 2'd3
  } state_t;

  state_t state;
  logic   kill_q;     // IF kill seen in the grant cycle of the pending IF read
  logic   if_turn;    // guard says IF must win a contested cycle

  // Byte-offset bits are meaningless to a word-wide RAM.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{if_addr[1:0], ma_addr[1:0]};

`ifdef RIP_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

  logic [CNT_W-1:0] streak;

  assign if_turn = (streak == CNT_W'(STREAK_MAX));

  // Count MA grants made while IF is waiting; any IF grant or idle IF clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (if_gnt || !if_req) begin
      streak <= '0;
    end else if (ma_gnt) begin
      streak <= streak + 1'b1;
    end
  end
`else
  localparam int unused_streak_max = STREAK_MAX;

  assign if_turn = 1'b0;
`endif

  // Grant selection: MA first unless the starvation guard hands IF the slot.
  always_comb begin
    if_gnt = 1'b0;
    ma_gnt = 1'b0;
    if (!rst) begin
      if (ma_req && !(if_req && if_turn)) begin
        ma_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // RAM port driven straight from the granted request; quiet when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr[ADDR_W-1:2];
      mem_wdata = ma_wdata;
    end else if (ma_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = ma_addr[ADDR_W-1:2];
      mem_we    = ma_we ? ma_be : 4'b0000;
      mem_wdata = ma_wdata;
    end
  end

  // Response FSM: remember who owns the access issued this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      kill_q <= 1'b0;
    end else begin
      kill_q <= if_gnt && if_kill;
      if (if_gnt) begin
        state <= ST_IF_RD;
      end else if (ma_gnt) begin
        state <= ma_we ? ST_MA_WR : ST_MA_RD;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Response routing; a kill in either the grant or the response cycle drops IF data.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'h0;
    ma_rvalid = 1'b0;
    ma_rdata  = 32'h0;
    if (!rst) begin
      case (state)
        ST_IF_RD: begin
          if (!kill_q && !if_kill) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end
        ST_MA_RD: begin
          ma_rvalid = 1'b1;
          ma_rdata  = mem_rdata;
        end
        ST_MA_WR: begin
          ma_rvalid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
